// File: rtl/rhythm_lock_pkg.sv
// Shared types and 7-segment encodings for the rhythm lock sequencer.
package rhythm_lock_pkg;

  localparam int unsigned SEG_W = 7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REC     = 3'd1,
    LISTEN  = 3'd2,
    CHECK   = 3'd3,
    OPEN    = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  // Segment bit0=a .. bit6=g, active high
  localparam logic [SEG_W-1:0] SEG_L    = 7'h38;
  localparam logic [SEG_W-1:0] SEG_P    = 7'h73;
  localparam logic [SEG_W-1:0] SEG_U    = 7'h3E;
  localparam logic [SEG_W-1:0] SEG_E    = 7'h79;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;

  // Decimal digit to segment pattern; out-of-range values show a dash
  function automatic logic [SEG_W-1:0] digit_to_seg(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rhythm_lock_ctrl_tick_div.sv
// Free-running tick prescaler: one-cycle tick every TICK_DIV enabled clocks.
module rhythm_tick_div #(
  parameter int unsigned TICK_DIV = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  // Count 0..TICK_DIV-1 and flag the wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (ena) begin
      if (cnt_q == CW'(TICK_DIV - 1)) begin
        cnt_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + CW'(1);
        tick_q <= 1'b0;
      end
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/rhythm_lock_ctrl.sv
// Rhythm lock sequencer: records tap intervals as a pattern and checks later attempts.
module rhythm_lock_ctrl
  import rhythm_lock_pkg::*;
#(
  parameter int unsigned N_TAPS     = 4,
  parameter int unsigned TICK_DIV   = 10000,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned TOL        = 8,
  parameter int unsigned TIMEOUT    = 1000,
  parameter int unsigned OPEN_TICKS = 3000,
  parameter int unsigned LOCK_TICKS = 5000,
  parameter int unsigned MAX_FAIL   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             tap,
  input  logic             prog,
  output logic [SEG_W-1:0] seg,
  output logic             unlocked,
  output logic             alarm,
  output logic             busy,
  output logic [1:0]       fail_cnt
);

  localparam int unsigned N_IVL  = N_TAPS - 1;
  localparam int unsigned AW     = (N_IVL > 1) ? $clog2(N_IVL) : 1;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DW_MAX = (OPEN_TICKS > LOCK_TICKS) ? OPEN_TICKS : LOCK_TICKS;
  localparam int unsigned DW_W   = $clog2(DW_MAX + 1);

  logic [2:0]       tap_s_q;
  logic [1:0]       prog_s_q;
  logic             tap_evt_q;
  logic             tick;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mis_q, mis_d;
  logic [1:0]       fail_q, fail_d;
  logic             pat_valid_q, pat_valid_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [CNT_W-1:0] ivl_q;
  logic [CNT_W-1:0] pat_q [N_IVL];
  logic [CNT_W-1:0] rec_q [N_IVL];
  logic             rec_we_c, commit_c;

  logic [SEG_W-1:0] seg_q, seg_d;
  logic             unlocked_q, unlocked_d;
  logic             alarm_q, alarm_d;
  logic             busy_q, busy_d;
  logic [1:0]       fail_cnt_q;

  logic [AW-1:0]    slot;
  logic [CNT_W:0]   a_ext, b_ext, diff;
  logic             over_tol, last_tap, timeout_hit;

  rhythm_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tick  (tick)
  );

  // Tap/prog synchronisers and registered rising-edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_s_q   <= '0;
      prog_s_q  <= '0;
      tap_evt_q <= 1'b0;
    end else if (ena) begin
      tap_s_q   <= {tap_s_q[1:0], tap};
      prog_s_q  <= {prog_s_q[0], prog};
      tap_evt_q <= tap_s_q[1] & ~tap_s_q[2];
    end
  end

  // Interval timer in ticks: restarts on every tap, saturates at full scale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ivl_q <= '0;
    end else if (ena) begin
      if (tap_evt_q)                ivl_q <= '0;
      else if (tick && ~&ivl_q)     ivl_q <= ivl_q + CNT_W'(1);
    end
  end

  assign slot        = AW'(idx_q - IDX_W'(1));
  assign a_ext       = {1'b0, ivl_q};
  assign b_ext       = {1'b0, pat_q[slot]};
  assign diff        = (a_ext >= b_ext) ? (a_ext - b_ext) : (b_ext - a_ext);
  assign over_tol    = diff > (CNT_W + 1)'(TOL);
  assign last_tap    = idx_q == IDX_W'(N_TAPS - 1);
  assign timeout_hit = ivl_q == CNT_W'(TIMEOUT);

  // Scratch intervals during REC; the live pattern only changes on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IVL; i++) begin
        rec_q[i] <= '0;
        pat_q[i] <= '0;
      end
    end else if (ena) begin
      if (rec_we_c) rec_q[slot] <= ivl_q;
      if (commit_c) begin
        for (int i = 0; i < N_IVL; i++) begin
          pat_q[i] <= (i == N_IVL - 1) ? ivl_q : rec_q[i];
        end
      end
    end
  end

  // FSM state and sequence bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mis_q       <= 1'b0;
      fail_q      <= '0;
      pat_valid_q <= 1'b0;
      dwell_q     <= '0;
    end else if (ena) begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mis_q       <= mis_d;
      fail_q      <= fail_d;
      pat_valid_q <= pat_valid_d;
      dwell_q     <= dwell_d;
    end
  end

  // Next-state logic; a tap always takes priority over a same-cycle timeout
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mis_d       = mis_q;
    fail_d      = fail_q;
    pat_valid_d = pat_valid_q;
    rec_we_c    = 1'b0;
    commit_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tap_evt_q) begin
          state_d = pat_valid_q ? LISTEN : REC;
          idx_d   = IDX_W'(1);
          mis_d   = 1'b0;
        end
      end
      REC: begin
        if (tap_evt_q) begin
          rec_we_c = 1'b1;
          idx_d    = idx_q + IDX_W'(1);
          if (last_tap) begin
            commit_c    = 1'b1;
            pat_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      LISTEN: begin
        if (tap_evt_q) begin
          if (over_tol) mis_d = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (last_tap) state_d = CHECK;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (!mis_q) begin
          state_d = OPEN;
          fail_d  = '0;
        end else if (({1'b0, fail_q} + 3'd1) == 3'(MAX_FAIL)) begin
          state_d = LOCKOUT;
        end else begin
          fail_d  = fail_q + 2'd1;
          state_d = IDLE;
        end
      end
      OPEN: begin
        if (tap_evt_q && prog_s_q[1]) begin
          state_d = REC;
          idx_d   = IDX_W'(1);
        end else if (dwell_q == DW_W'(OPEN_TICKS)) begin
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
        if (dwell_q == DW_W'(LOCK_TICKS)) begin
          state_d = IDLE;
          fail_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q)           dwell_d = '0;
    else if (tick && ~&dwell_q)       dwell_d = dwell_q + DW_W'(1);
    else                              dwell_d = dwell_q;
  end

  // Output decode from the current state
  always_comb begin
    seg_d      = SEG_L;
    unlocked_d = 1'b0;
    alarm_d    = 1'b0;
    busy_d     = 1'b0;
    case (state_q)
      IDLE:    seg_d = SEG_L;
      REC: begin
        busy_d = 1'b1;
        seg_d  = (idx_q == IDX_W'(1)) ? SEG_P : digit_to_seg(idx_q);
      end
      LISTEN: begin
        busy_d = 1'b1;
        seg_d  = digit_to_seg(idx_q);
      end
      CHECK: begin
        busy_d = 1'b1;
        seg_d  = SEG_DASH;
      end
      OPEN: begin
        unlocked_d = 1'b1;
        seg_d      = SEG_U;
      end
      LOCKOUT: begin
        alarm_d = 1'b1;
        seg_d   = SEG_E;
      end
      default: seg_d = SEG_L;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q      <= SEG_L;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      busy_q     <= 1'b0;
      fail_cnt_q <= '0;
    end else if (ena) begin
      seg_q      <= seg_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
      busy_q     <= busy_d;
      fail_cnt_q <= fail_q;
    end
  end

  assign seg      = seg_q;
  assign unlocked = unlocked_q;
  assign alarm    = alarm_q;
  assign busy     = busy_q;
  assign fail_cnt = fail_cnt_q;

endmodule
